// File: rtl/invquant_stream.sv
// invquant_stream: inverse quantizer for one 4x4 block of transform levels.
// A block is captured on in_valid & in_ready, rescaled LANES coefficients per
// clock, and presented on out_coef with out_valid until out_ready drains it.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   input block present
//   in_ready   block can be accepted (IDLE only)
//   in_coef    16 signed IN_W levels, raster order
//   in_qp      quantizer parameter, values above 51 are clamped to 51
//   in_mode    0 = 4x4 residual, 1 = luma DC, 2 = chroma DC 2x2, 3 = as 0
//   out_valid  rescaled block present (DONE only)
//   out_ready  downstream accepts block
//   out_coef   16 signed OUT_W rescaled coefficients, raster order
//   out_sat    at least one coefficient of the block saturated
module invquant_stream #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [15:0][IN_W-1:0]  in_coef,
    input  logic [5:0]             in_qp,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0][OUT_W-1:0] out_coef,
    output logic                   out_sat
);

    localparam int unsigned WW     = IN_W + 14;
    localparam int unsigned N_FULL = 16 / LANES;
    localparam int unsigned N_DC   = (4 + LANES - 1) / LANES;
    localparam logic [4:0]  LAST_FULL = 5'(N_FULL - 1);
    localparam logic [4:0]  LAST_DC   = 5'(N_DC - 1);
    localparam logic signed [WW-1:0] SAT_MAX = WW'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [WW-1:0] ONE     = WW'(1);
    localparam logic signed [WW-1:0] TWO     = WW'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0][IN_W-1:0] coef_q;
    logic [5:0]            qp_q;
    logic [1:0]            mode_q;
    logic [4:0]            beat;

    logic                  accept_c;
    logic                  last_beat_c;
    logic [3:0]            qd_c;
    logic [2:0]            qm_c;
    logic [3:0]            lane_idx [LANES];
    logic signed [WW-1:0]  lane_raw [LANES];
    logic signed [WW-1:0]  lane_val [LANES];
    logic [LANES-1:0]      lane_sat;

    // Scale factor lookup; cls 0 = even/even positions, 1 = odd/odd, 2 = mixed.
    function automatic logic [4:0] factor(input logic [1:0] cls, input logic [2:0] qm);
        logic [4:0] f;
        f = 5'd0;
        case (cls)
            2'd1: begin
                case (qm)
                    3'd0:    f = 5'd16;
                    3'd1:    f = 5'd18;
                    3'd2:    f = 5'd20;
                    3'd3:    f = 5'd23;
                    3'd4:    f = 5'd25;
                    default: f = 5'd29;
                endcase
            end
            2'd2: begin
                case (qm)
                    3'd0:    f = 5'd13;
                    3'd1:    f = 5'd14;
                    3'd2:    f = 5'd16;
                    3'd3:    f = 5'd18;
                    3'd4:    f = 5'd20;
                    default: f = 5'd23;
                endcase
            end
            default: begin
                case (qm)
                    3'd0:    f = 5'd10;
                    3'd1:    f = 5'd11;
                    3'd2:    f = 5'd13;
                    3'd3:    f = 5'd14;
                    3'd4:    f = 5'd16;
                    default: f = 5'd18;
                endcase
            end
        endcase
        return f;
    endfunction

    // Unsaturated rescale of one coefficient at raster position idx.
    function automatic logic signed [WW-1:0] rescale(
        input logic [IN_W-1:0] x,
        input logic [1:0]      mode,
        input logic [5:0]      qp,
        input logic [3:0]      qd,
        input logic [2:0]      qm,
        input logic [3:0]      idx
    );
        logic signed [WW-1:0] xe;
        logic signed [WW-1:0] fe;
        logic signed [WW-1:0] prod;
        logic signed [WW-1:0] r;
        logic [1:0]           cls;
        cls = 2'd0;
        // idx[0] is column parity, idx[2] is row parity
        if ((mode == 2'd0 || mode == 2'd3) && !(idx[0] == 1'b0 && idx[2] == 1'b0)) begin
            cls = (idx[0] && idx[2]) ? 2'd1 : 2'd2;
        end
        xe   = WW'($signed(x));
        fe   = $signed(WW'(factor(cls, qm)));
        prod = xe * fe;
        r    = '0;
        case (mode)
            2'd1: begin
                if (qp >= 6'd12) begin
                    r = prod <<< (qd - 4'd2);
                end else if (qd == 4'd0) begin
                    r = (prod + TWO) >>> 2;
                end else begin
                    r = (prod + ONE) >>> 1;
                end
            end
            2'd2: begin
                if (idx < 4'd4) begin
                    r = (prod <<< qd) >>> 1;
                end
            end
            default: r = prod <<< qd;
        endcase
        return r;
    endfunction

    // Lane datapath: rescale and saturate the current beat's coefficients.
    always_comb begin
        qd_c     = 4'(qp_q / 6'd6);
        qm_c     = 3'(qp_q % 6'd6);
        lane_sat = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_idx[l] = 4'(32'(beat) * LANES + 32'(l));
            lane_raw[l] = rescale(coef_q[lane_idx[l]], mode_q, qp_q, qd_c, qm_c, lane_idx[l]);
            lane_val[l] = lane_raw[l];
            if (lane_raw[l] > SAT_MAX) begin
                lane_val[l] = SAT_MAX;
                lane_sat[l] = 1'b1;
            end else if (lane_raw[l] < SAT_MIN) begin
                lane_val[l] = SAT_MIN;
                lane_sat[l] = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next  = state;
        accept_c    = 1'b0;
        last_beat_c = (beat == ((mode_q == 2'd2) ? LAST_DC : LAST_FULL));
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c   = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_beat_c) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // Block capture, beat counter and result accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coef_q   <= '0;
            qp_q     <= '0;
            mode_q   <= '0;
            beat     <= '0;
            out_coef <= '0;
            out_sat  <= 1'b0;
        end else if (accept_c) begin
            coef_q   <= in_coef;
            qp_q     <= (in_qp > 6'd51) ? 6'd51 : in_qp;
            mode_q   <= in_mode;
            beat     <= '0;
            // clearing here leaves unvisited chroma-DC positions at zero
            out_coef <= '0;
            out_sat  <= 1'b0;
        end else if (state == BUSY) begin
            beat <= beat + 5'd1;
            for (int l = 0; l < int'(LANES); l++) begin
                out_coef[lane_idx[l]] <= OUT_W'(lane_val[l]);
            end
            out_sat <= out_sat | (|lane_sat);
        end
    end

endmodule

// File: tb/tb_invquant_stream.sv
module tb_invquant_stream;

    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 16;
    localparam int unsigned LANES = 4;

    typedef logic [15:0][IN_W-1:0]  cin_t;
    typedef logic [15:0][OUT_W-1:0] cout_t;

    logic  clk       = 1'b0;
    logic  reset     = 1'b0;
    logic  in_valid  = 1'b0;
    logic  in_ready;
    cin_t  in_coef   = '0;
    logic [5:0] in_qp   = '0;
    logic [1:0] in_mode = '0;
    logic  out_valid;
    logic  out_ready = 1'b0;
    cout_t out_coef;
    logic  out_sat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    invquant_stream #(.IN_W(IN_W), .OUT_W(OUT_W), .LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_coef   (in_coef),
        .in_qp     (in_qp),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_sat   (out_sat)
    );

    // ---------------- reference model ----------------
    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint model_raw(input longint x, input int qp, input int mode, input int i);
        int fa[6] = '{10, 11, 13, 14, 16, 18};
        int fb[6] = '{16, 18, 20, 23, 25, 29};
        int fc[6] = '{13, 14, 16, 18, 20, 23};
        int q, qd, qm, row, col;
        longint p2, f;
        q   = (qp > 51) ? 51 : qp;
        qd  = q / 6;
        qm  = q % 6;
        row = i / 4;
        col = i % 4;
        p2  = longint'(1) << qd;
        if (mode == 2) begin
            if (i >= 4) return 0;
            return floor_div(x * fa[qm] * p2, 2);
        end
        if (mode == 1) begin
            if (q >= 12) return x * fa[qm] * (p2 / 4);
            return floor_div(x * fa[qm] + 2 / p2, 4 / p2);
        end
        if (row % 2 == 0 && col % 2 == 0)      f = fa[qm];
        else if (row % 2 == 1 && col % 2 == 1) f = fb[qm];
        else                                    f = fc[qm];
        return x * f * p2;
    endfunction

    function automatic longint clip(input longint v);
        longint hi, lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint sx(input logic [IN_W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint so(input logic [OUT_W-1:0] v);
        return longint'($signed(v));
    endfunction

    // ---------------- driver ----------------
    // Sends one block, scrambles inputs after accept, waits for the result,
    // returns it with the edge count from accept to out_valid, then drains.
    task automatic send_block(input cin_t c, input int qp, input int mode,
                              output cout_t oc, output logic os, output int lat);
        int n;
        n = 0;
        in_coef  = c;
        in_qp    = 6'(qp);
        in_mode  = 2'(mode);
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) in_coef[i] = IN_W'($urandom);
        in_qp   = 6'($urandom);
        in_mode = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        oc = out_coef;
        os = out_sat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    function automatic cin_t rand_block();
        cin_t c;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) c[i] = IN_W'($urandom_range(0, 127) - 64);
            else                           c[i] = IN_W'($urandom);
        end
        return c;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sat !== 1'b0 || out_coef !== '0) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_sat=%b coef=%h want 0 0 0 0",
                     in_ready, out_valid, out_sat, out_coef);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_release: got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        cin_t  c;
        cout_t oc;
        logic  os;
        int    lat;

        for (int i = 0; i < 16; i++) c[i] = IN_W'(1);
        send_block(c, 0, 0, oc, os, lat);
        vectors++;
        if (so(oc[0]) != 10 || so(oc[1]) != 13 || so(oc[5]) != 16 || os !== 1'b0) begin
            miscompares++;
            $display("FAIL ones_qp0: got %0d %0d %0d sat=%b want 10 13 16 sat=0",
                     so(oc[0]), so(oc[1]), so(oc[5]), os);
        end
        vectors++;
        if (lat != 4) begin
            miscompares++;
            $display("FAIL latency_mode0: got %0d want 4", lat);
        end

        c = '0; c[0] = IN_W'(-3); c[15] = IN_W'(2);
        send_block(c, 28, 0, oc, os, lat);
        vectors++;
        if (so(oc[0]) != -768 || so(oc[15]) != 800 || os !== 1'b0) begin
            miscompares++;
            $display("FAIL qp28: got %0d %0d sat=%b want -768 800 sat=0", so(oc[0]), so(oc[15]), os);
        end

        c = '0; c[0] = IN_W'(5); c[1] = IN_W'(-5);
        send_block(c, 6, 1, oc, os, lat);
        vectors++;
        if (so(oc[0]) != 25 || so(oc[1]) != -25) begin
            miscompares++;
            $display("FAIL luma_dc_qp6: got %0d %0d want 25 -25", so(oc[0]), so(oc[1]));
        end

        c = '0; c[0] = IN_W'(3);
        send_block(c, 18, 1, oc, os, lat);
        vectors++;
        if (so(oc[0]) != 60) begin
            miscompares++;
            $display("FAIL luma_dc_qp18: got %0d want 60", so(oc[0]));
        end

        c = '0; c[0] = IN_W'(7); c[4] = IN_W'(9);
        send_block(c, 0, 2, oc, os, lat);
        vectors++;
        if (so(oc[0]) != 35 || so(oc[4]) != 0) begin
            miscompares++;
            $display("FAIL chroma_dc: got %0d %0d want 35 0", so(oc[0]), so(oc[4]));
        end
        vectors++;
        if (lat != 1) begin
            miscompares++;
            $display("FAIL latency_mode2: got %0d want 1", lat);
        end

        c = '0; c[0] = IN_W'(100);
        send_block(c, 51, 0, oc, os, lat);
        vectors++;
        if (so(oc[0]) != 32767 || os !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_pos: got %0d sat=%b want 32767 sat=1", so(oc[0]), os);
        end

        c = '0; c[0] = IN_W'(-100);
        send_block(c, 51, 0, oc, os, lat);
        vectors++;
        if (so(oc[0]) != -32768 || os !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_neg: got %0d sat=%b want -32768 sat=1", so(oc[0]), os);
        end

        c = '0; c[0] = IN_W'(1); c[5] = IN_W'(1);
        send_block(c, 63, 0, oc, os, lat);
        vectors++;
        if (so(oc[0]) != 3584 || so(oc[5]) != 5888 || os !== 1'b0) begin
            miscompares++;
            $display("FAIL qp_clamp: got %0d %0d sat=%b want 3584 5888 sat=0", so(oc[0]), so(oc[5]), os);
        end
    endtask

    task automatic test_random();
        cin_t   c;
        cout_t  oc;
        logic   os;
        int     lat, qp, mode, want_lat;
        longint raw, exp_v;
        logic   exp_sat;
        for (int b = 0; b < 150; b++) begin
            c    = rand_block();
            qp   = int'($urandom_range(0, 63));
            mode = int'($urandom_range(0, 3));
            send_block(c, qp, mode, oc, os, lat);
            exp_sat = 1'b0;
            for (int i = 0; i < 16; i++) begin
                raw   = model_raw(sx(c[i]), qp, mode, i);
                exp_v = clip(raw);
                if (exp_v != raw) exp_sat = 1'b1;
                vectors++;
                if (so(oc[i]) != exp_v) begin
                    miscompares++;
                    $display("FAIL rand_coef blk=%0d idx=%0d mode=%0d qp=%0d x=%0d: got %0d want %0d",
                             b, i, mode, qp, sx(c[i]), so(oc[i]), exp_v);
                end
            end
            vectors++;
            if (os !== exp_sat) begin
                miscompares++;
                $display("FAIL rand_sat blk=%0d: got %b want %b", b, os, exp_sat);
            end
            want_lat = (mode == 2) ? (4 + int'(LANES) - 1) / int'(LANES) : 16 / int'(LANES);
            vectors++;
            if (lat != want_lat) begin
                miscompares++;
                $display("FAIL rand_latency blk=%0d: got %0d want %0d", b, lat, want_lat);
            end
        end
    endtask

    task automatic test_backpressure();
        cin_t  c;
        cout_t snap;
        logic  snap_sat;
        int    n;
        c = rand_block();
        in_coef  = c;
        in_qp    = 6'd30;
        in_mode  = 2'd0;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        snap     = out_coef;
        snap_sat = out_sat;
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (so(snap[i]) != clip(model_raw(sx(c[i]), 30, 0, i))) begin
                miscompares++;
                $display("FAIL bp_value idx=%0d: got %0d want %0d", i, so(snap[i]),
                         clip(model_raw(sx(c[i]), 30, 0, i)));
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_coef !== snap || out_sat !== snap_sat) begin
                miscompares++;
                $display("FAIL bp_hold cyc=%0d: valid=%b ready=%b stable=%b want 1 0 1",
                         k, out_valid, in_ready, (out_coef === snap && out_sat === snap_sat));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // next block is cut off by reset partway through its beats
        in_coef  = rand_block();
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_coef !== '0 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: valid=%b ready=%b coef=%h sat=%b want 0 0 0 0",
                     out_valid, in_ready, out_coef, out_sat);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL after_reset cyc=%0d: valid=%b ready=%b want 0 1", k, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_directed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/invquant_stream.md
INVQUANT_STREAM -- requirements
Module: invquant_stream

Interface
REQ-001 Parameter IN_W, default 16, signed input coefficient width.
REQ-002 Parameter OUT_W, default 16, signed output coefficient width.
REQ-003 Parameter LANES, default 4, coefficients rescaled per cycle; legal values 1, 2, 4, 8, 16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  input  1  input block present.
REQ-007 in_ready  output  1  block can be accepted.
REQ-008 in_coef  input  16 x IN_W signed  quantized 4x4 levels, raster order, index 0..15.
REQ-009 in_qp  input  6  quantizer parameter 0..51.
REQ-010 in_mode  input  2  0 = 4x4 residual, 1 = luma DC 4x4, 2 = chroma DC 2x2, 3 = treated as 0.
REQ-011 out_valid  output  1  rescaled block present.
REQ-012 out_ready  input  1  downstream accepts block.
REQ-013 out_coef  output  16 x OUT_W signed  rescaled coefficients, raster order.
REQ-014 out_sat  output  1  at least one coefficient of the current output block saturated.

Function
REQ-015 The block SHALL accept an input block on a rising edge where in_valid and in_ready are both 1, capturing in_coef, in_qp (values above 51 clamped to 51) and in_mode.
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE: IDLE to BUSY on accept; BUSY to DONE on the edge processing the last lane group; DONE to IDLE on out_valid and out_ready both 1.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; no new block is accepted in the same cycle a result is drained.
REQ-018 In BUSY, each edge SHALL rescale coefficients [g*LANES .. g*LANES+LANES-1] for beat counter g = 0, 1, ... and write them to out_coef.
REQ-019 The beat count N SHALL be 16/LANES for modes 0, 1 and 3, and ceil(4/LANES) for mode 2.
REQ-020 out_valid SHALL rise exactly N rising edges after the accepting edge.
REQ-021 Let qd = qp/6 and qm = qp mod 6; factor class A = {10,11,13,14,16,18}, class B = {16,18,20,23,25,29} and class C = {13,14,16,18,20,23}, indexed by qm.
REQ-022 Mode 0 class mapping SHALL be: indices 0, 2, 8, 10 use A; indices 5, 7, 13, 15 use B; all other indices use C.
REQ-023 Mode 0 result SHALL be (x*f) << qd.
REQ-024 Mode 1 SHALL use class A for all 16 indices.
REQ-025 Mode 1 with qp >= 12 SHALL compute (x*f) << (qd-2).
REQ-026 Mode 1 with qp < 12 SHALL compute (x*f + 2^(1-qd)) >>> (2-qd).
REQ-027 Mode 2 SHALL use class A for indices 0..3 and compute ((x*f) << qd) >>> 1; indices 4..15 SHALL output 0.
REQ-028 The shift >>> is arithmetic, i.e. floor for negative values.
REQ-029 Intermediate arithmetic SHALL be at least IN_W+14 bits signed, so no internal overflow occurs.
REQ-030 Each result SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-031 out_sat SHALL clear on accept and set if any coefficient of the block saturates.
REQ-032 While out_valid=1 and out_ready=0, out_coef and out_sat SHALL hold stable.
REQ-033 in_coef, in_qp and in_mode changes after the accepting edge SHALL NOT affect the result.

Reset
REQ-034 While reset=0, the state SHALL be IDLE, out_valid=0, in_ready=0, every out_coef=0, out_sat=0 and the beat counter=0.
REQ-035 in_ready SHALL be 1 from the first rising edge after reset is released.
REQ-036 Reset asserted in BUSY or DONE SHALL discard the block in flight, with no out_valid pulse for it.

Verification
REQ-037 LANES=4, mode 0, qp=0, all in_coef=1 -> out_coef[0]=10, [1]=13, [5]=16; out_valid exactly 4 edges after accept.
REQ-038 mode 0, qp=28, in_coef[0]=-3, in_coef[15]=2 -> out_coef[0]=-768, out_coef[15]=800, out_sat=0.
REQ-039 mode 1, qp=6: x=5 -> 25 and x=-5 -> -25. mode 1, qp=18: x=3 -> 60.
REQ-040 mode 2, qp=0, in_coef[0]=7, in_coef[4]=9 -> out_coef[0]=35, out_coef[4]=0; with LANES=4, out_valid 1 edge after accept.
REQ-041 mode 0, qp=51, in_coef[0]=100 with OUT_W=16 -> out_coef[0]=32767 and out_sat=1; in_coef[0]=-100 -> -32768.
REQ-042 Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; then assert reset mid-BUSY of the next block -> out_valid stays 0 and in_ready=1 after release.
